// File: rtl/step_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : step_sequencer_if                                         |
// | Purpose  : Control/pattern/playback bundle of the step sequencer.    |
// |            master = controller side (buttons, pattern writer),       |
// |            slave  = sequencer side.                                  |
// | Signals  : enable, bpm_up, bpm_dn, map_sel      controls  (m -> s)   |
// |            wr_en, wr_map, wr_step, wr_data      pattern   (m -> s)   |
// |            bpm_value, note_ms, map_active,                           |
// |            step_idx, cur_sample, step_strobe,                        |
// |            bar_start                            playback  (s -> m)   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface step_sequencer_if #(
  parameter int STEPS    = 32,
  parameter int NUM_MAPS = 4,
  parameter int VOICE_W  = 3
) ();
  localparam int MAP_W  = $clog2(NUM_MAPS);
  localparam int STEP_W = $clog2(STEPS);

  logic               enable;
  logic               bpm_up;
  logic               bpm_dn;
  logic [MAP_W-1:0]   map_sel;
  logic               wr_en;
  logic [MAP_W-1:0]   wr_map;
  logic [STEP_W-1:0]  wr_step;
  logic [VOICE_W-1:0] wr_data;
  logic [7:0]         bpm_value;
  logic [9:0]         note_ms;
  logic [MAP_W-1:0]   map_active;
  logic [STEP_W-1:0]  step_idx;
  logic [VOICE_W-1:0] cur_sample;
  logic               step_strobe;
  logic               bar_start;

  modport master (
    output enable, bpm_up, bpm_dn, map_sel, wr_en, wr_map, wr_step, wr_data,
    input  bpm_value, note_ms, map_active, step_idx, cur_sample, step_strobe, bar_start
  );

  modport slave (
    input  enable, bpm_up, bpm_dn, map_sel, wr_en, wr_map, wr_step, wr_data,
    output bpm_value, note_ms, map_active, step_idx, cur_sample, step_strobe, bar_start
  );
endinterface
`default_nettype wire

// File: rtl/step_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : step_sequencer                                            |
// | Purpose  : Drum-pattern sequencer. Plays per-step sample codes from  |
// |            NUM_MAPS writable pattern maps; step length is an eighth  |
// |            note derived from a clamped, button-adjusted BPM value    |
// |            through a sequential 30000/BPM divider.                   |
// | Ports    : clk, nrst (async active-low)                              |
// |            bus (step_sequencer_if.slave): controls, pattern writes,  |
// |            bpm_value/note_ms, map_active/step_idx/cur_sample,        |
// |            step_strobe/bar_start                                     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module step_sequencer #(
  parameter int TICK_DIV = 50000,
  parameter int STEPS    = 32,
  parameter int VOICE_W  = 3,
  parameter int NUM_MAPS = 4,
  parameter int BPM_INIT = 140,
  parameter int BPM_MIN  = 60,
  parameter int BPM_MAX  = 250,
  parameter int BPM_STEP = 5
) (
  input  logic             clk,
  input  logic             nrst,
  step_sequencer_if.slave  bus
);
  localparam int MAP_W  = $clog2(NUM_MAPS);
  localparam int STEP_W = $clog2(STEPS);
  localparam int TICK_W = $clog2(TICK_DIV + 1);

  localparam logic [14:0]       DIVIDEND  = 15'd30000;
  localparam logic [9:0]        NOTE_INIT = 10'(30000 / BPM_INIT);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state;
  logic [TICK_W-1:0]   tick_cnt;
  logic [9:0]          ms_cnt;
  logic [VOICE_W-1:0]  pattern [NUM_MAPS][STEPS];

  // ---------------- BPM adjust with clamping ----------------
  logic [7:0] bpm_next;
  logic       bpm_change;

  always_comb begin
    bpm_next = bus.bpm_value;
    if (bus.bpm_up && !bus.bpm_dn) begin
      if ({1'b0, bus.bpm_value} + 9'(BPM_STEP) > 9'(BPM_MAX))
        bpm_next = 8'(BPM_MAX);
      else
        bpm_next = bus.bpm_value + 8'(BPM_STEP);
    end else if (bus.bpm_dn && !bus.bpm_up) begin
      if ({1'b0, bus.bpm_value} < 9'(BPM_MIN + BPM_STEP))
        bpm_next = 8'(BPM_MIN);
      else
        bpm_next = bus.bpm_value - 8'(BPM_STEP);
    end
  end

  assign bpm_change = (bpm_next != bus.bpm_value);

  // ---------------- restoring divider: note_ms = 30000 / bpm ----------------
  // div_quo starts as the dividend and is shifted left, quotient bits
  // entering at the bottom. The remainder always stays below the divisor,
  // so 8-bit modular subtraction gives the exact restored remainder.
  logic        div_busy;
  logic        div_done;
  logic [3:0]  div_cnt;
  logic [7:0]  div_rem;
  logic [14:0] div_quo;
  logic [7:0]  div_dvsr;
  logic [8:0]  div_trial;
  logic        div_fits;
  logic [7:0]  div_rem_next;

  always_comb begin
    div_trial    = {div_rem, div_quo[14]};
    div_fits     = (div_trial >= {1'b0, div_dvsr});
    div_rem_next = div_fits ? (div_trial[7:0] - div_dvsr) : div_trial[7:0];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bus.bpm_value <= 8'(BPM_INIT);
      bus.note_ms   <= NOTE_INIT;
      div_busy      <= 1'b0;
      div_done      <= 1'b0;
      div_cnt       <= 4'd0;
      div_rem       <= 8'd0;
      div_quo       <= 15'd0;
      div_dvsr      <= 8'd0;
    end else begin
      bus.bpm_value <= bpm_next;
      if (bpm_change) begin
        // Any change (re)starts the division from scratch.
        div_busy <= 1'b1;
        div_done <= 1'b0;
        div_cnt  <= 4'd0;
        div_rem  <= 8'd0;
        div_quo  <= DIVIDEND;
        div_dvsr <= bpm_next;
      end else if (div_busy) begin
        div_rem <= div_rem_next;
        div_quo <= {div_quo[13:0], div_fits};
        div_cnt <= div_cnt + 4'd1;
        if (div_cnt == 4'd14) begin
          div_busy <= 1'b0;
          div_done <= 1'b1;
        end
      end else begin
        div_done <= 1'b0;
      end
      if (div_done)
        bus.note_ms <= div_quo[9:0];
    end
  end

  // ---------------- pattern memory ----------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int m = 0; m < NUM_MAPS; m++)
        for (int s = 0; s < STEPS; s++)
          pattern[m][s] <= '0;
    end else if (bus.wr_en) begin
      pattern[bus.wr_map][bus.wr_step] <= bus.wr_data;
    end
  end

  // Address of the sample needed at the next step start: step 0 of the
  // requested map on entry or bar wrap, otherwise the next step of the
  // playing map. A write landing on that entry in the same cycle is
  // forwarded so it is heard when the step plays.
  logic              ms_tick;
  logic              advance;
  logic [MAP_W-1:0]  rd_map;
  logic [STEP_W-1:0] rd_step;
  logic [VOICE_W-1:0] rd_data;

  always_comb begin
    ms_tick = (tick_cnt == TICK_LAST);
    advance = ms_tick && (ms_cnt >= bus.note_ms - 10'd1);
    if (state == IDLE || bus.step_idx == LAST_STEP) begin
      rd_map  = bus.map_sel;
      rd_step = '0;
    end else begin
      rd_map  = bus.map_active;
      rd_step = bus.step_idx + STEP_W'(1);
    end
    if (bus.wr_en && bus.wr_map == rd_map && bus.wr_step == rd_step)
      rd_data = bus.wr_data;
    else
      rd_data = pattern[rd_map][rd_step];
  end

  // ---------------- playback FSM ----------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state           <= IDLE;
      tick_cnt        <= '0;
      ms_cnt          <= 10'd0;
      bus.step_idx    <= '0;
      bus.map_active  <= '0;
      bus.cur_sample  <= '0;
      bus.step_strobe <= 1'b0;
      bus.bar_start   <= 1'b0;
    end else begin
      bus.step_strobe <= 1'b0;
      bus.bar_start   <= 1'b0;
      case (state)
        IDLE: begin
          tick_cnt       <= '0;
          ms_cnt         <= 10'd0;
          bus.step_idx   <= '0;
          bus.cur_sample <= '0;
          if (bus.enable) begin
            state           <= RUN;
            bus.map_active  <= bus.map_sel;
            bus.cur_sample  <= rd_data;
            bus.step_strobe <= 1'b1;
            bus.bar_start   <= 1'b1;
          end
        end
        RUN: begin
          if (!bus.enable) begin
            state          <= IDLE;
            tick_cnt       <= '0;
            ms_cnt         <= 10'd0;
            bus.step_idx   <= '0;
            bus.cur_sample <= '0;
          end else begin
            tick_cnt <= ms_tick ? '0 : tick_cnt + TICK_W'(1);
            if (advance) begin
              ms_cnt          <= 10'd0;
              bus.step_strobe <= 1'b1;
              bus.cur_sample  <= rd_data;
              if (bus.step_idx == LAST_STEP) begin
                bus.step_idx   <= '0;
                bus.map_active <= bus.map_sel;
                bus.bar_start  <= 1'b1;
              end else begin
                bus.step_idx <= bus.step_idx + STEP_W'(1);
              end
            end else if (ms_tick) begin
              ms_cnt <= ms_cnt + 10'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
